// File: rtl/arb5_pkg.sv
// Shared constants, state encoding and index helper for the five-way
// round-robin arbiter.
package arb5_pkg;

   localparam int NREQ = 5;
   localparam int ID_W = 3;

   // Exclude index value that matches no requester (used while idle).
   localparam logic [ID_W-1:0] NO_EXCL = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Advance a requester index by one, wrapping 4 -> 0.
   function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
      return (idx == 3'd4) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotating-priority picker: scans the effective requests
// starting at ptr and moving upward mod 5, skipping the excluded index,
// and reports the first hit as one-hot, binary index and a found flag.
module rr_pick5
   import arb5_pkg::*;
(
   input  logic [NREQ-1:0] ereq,
   input  logic [ID_W-1:0] ptr,
   input  logic [ID_W-1:0] excl,
   output logic [NREQ-1:0] win_oh,
   output logic [ID_W-1:0] win_id,
   output logic            found
);

   logic [NREQ-1:0] cand;
   logic [ID_W-1:0] scan_idx;
   logic            hit;

   // Remove the excluded requester from the candidate set.
   always_comb begin
      cand = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand[i] = ereq[i] & (excl != ID_W'(i));
      end
   end

   // Walk the five positions in priority order and latch the first hit.
   always_comb begin
      win_oh   = '0;
      win_id   = '0;
      found    = 1'b0;
      hit      = 1'b0;
      scan_idx = ptr;
      for (int k = 0; k < NREQ; k++) begin
         hit      = !found && cand[scan_idx];
         win_oh   = hit ? (NREQ'(1) << scan_idx) : win_oh;
         win_id   = hit ? scan_idx : win_id;
         found    = found | hit;
         scan_idx = next_idx(scan_idx);
      end
   end

endmodule

// File: rtl/arb5_rr.sv
// Five-way round-robin arbiter with registered one-hot grant, rotating
// priority pointer and a bounded grant-hold counter for fairness.
module arb5_rr
   import arb5_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
)
(
   input  logic            CK,
   input  logic            CD,
   input  logic [NREQ-1:0] REQ,
   input  logic [NREQ-1:0] MASK,
   output logic [NREQ-1:0] GNT,
   output logic            GNT_VLD,
   output logic [ID_W-1:0] GNT_ID,
   output logic            ANY
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t          state_r, state_nxt_s;
   logic [NREQ-1:0] gnt_r, gnt_nxt_s;
   logic [ID_W-1:0] id_r, id_nxt_s;
   logic            vld_r;
   logic [ID_W-1:0] ptr_r, ptr_nxt_s;
   logic [CNT_W-1:0] hold_r, hold_nxt_s;

   logic [NREQ-1:0] ereq_s;
   logic [ID_W-1:0] excl_s;
   logic [NREQ-1:0] win_oh_s;
   logic [ID_W-1:0] win_id_s;
   logic            found_s;
   logic            release_s;

   assign ereq_s = REQ & ~MASK;
   assign ANY    = |ereq_s;

   // While granting, the current grantee is excluded from the next search.
   assign excl_s = (state_r == GRANT) ? id_r : NO_EXCL;

   // Release on drop/mask of the grantee, or on timeout with a competitor waiting.
   assign release_s = (state_r == GRANT) &&
                      (!ereq_s[id_r] ||
                       ((hold_r == HOLD_LAST) && (|(ereq_s & ~gnt_r))));

   rr_pick5 u_pick (
      .ereq   (ereq_s),
      .ptr    (ptr_r),
      .excl   (excl_s),
      .win_oh (win_oh_s),
      .win_id (win_id_s),
      .found  (found_s)
   );

   // Next-state, next-grant, pointer and hold-counter decisions.
   always_comb begin
      state_nxt_s = state_r;
      gnt_nxt_s   = gnt_r;
      id_nxt_s    = id_r;
      ptr_nxt_s   = ptr_r;
      hold_nxt_s  = hold_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_nxt_s = GRANT;
               gnt_nxt_s   = win_oh_s;
               id_nxt_s    = win_id_s;
               ptr_nxt_s   = next_idx(win_id_s);
               hold_nxt_s  = '0;
            end else begin
               state_nxt_s = IDLE;
               gnt_nxt_s   = '0;
               id_nxt_s    = '0;
            end
         end
         GRANT: begin
            if (release_s) begin
               if (found_s) begin
                  // Direct hand-off, no idle gap.
                  state_nxt_s = GRANT;
                  gnt_nxt_s   = win_oh_s;
                  id_nxt_s    = win_id_s;
                  ptr_nxt_s   = next_idx(win_id_s);
                  hold_nxt_s  = '0;
               end else begin
                  state_nxt_s = IDLE;
                  gnt_nxt_s   = '0;
                  id_nxt_s    = '0;
                  hold_nxt_s  = '0;
               end
            end else if (hold_r == HOLD_LAST) begin
               // Timeout with nobody else waiting: keep grant, restart count.
               hold_nxt_s = '0;
            end else begin
               hold_nxt_s = hold_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            gnt_nxt_s   = '0;
            id_nxt_s    = '0;
            hold_nxt_s  = '0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by CD.
   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         state_r <= IDLE;
         gnt_r   <= '0;
         id_r    <= '0;
         vld_r   <= 1'b0;
         ptr_r   <= '0;
         hold_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         gnt_r   <= gnt_nxt_s;
         id_r    <= id_nxt_s;
         vld_r   <= |gnt_nxt_s;
         ptr_r   <= ptr_nxt_s;
         hold_r  <= hold_nxt_s;
      end
   end

   assign GNT     = gnt_r;
   assign GNT_VLD = vld_r;
   assign GNT_ID  = id_r;

endmodule

// File: tb/tb_arb5_rr.sv
// Self-checking bench for arb5_rr: directed scenarios plus a randomized run
// compared against a behavioural round-robin model.
module tb_arb5_rr;

   localparam int MAX_HOLD = 4;

   logic       CK = 1'b0;
   logic       CD;
   logic [4:0] REQ;
   logic [4:0] MASK;
   logic [4:0] GNT;
   logic       GNT_VLD;
   logic [2:0] GNT_ID;
   logic       ANY;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: current grantee (-1 = idle), priority start, hold count.
   int m_id;
   int m_ptr;
   int m_hold;

   arb5_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .CK      (CK),
      .CD      (CD),
      .REQ     (REQ),
      .MASK    (MASK),
      .GNT     (GNT),
      .GNT_VLD (GNT_VLD),
      .GNT_ID  (GNT_ID),
      .ANY     (ANY)
   );

   always #5 CK = ~CK;

   // First set bit scanning upward from ptr, mod 5; -1 if none.
   function automatic int m_search(input logic [4:0] bits, input int ptr);
      for (int k = 0; k < 5; k++) begin
         if (bits[(ptr + k) % 5]) return (ptr + k) % 5;
      end
      return -1;
   endfunction

   // Expected {GNT, GNT_VLD, GNT_ID} from the model state.
   function automatic logic [8:0] m_out();
      logic [4:0] g;
      g = 5'd0;
      if (m_id >= 0) g = 5'b00001 << m_id;
      return {g, (m_id >= 0), (m_id >= 0) ? 3'(m_id) : 3'd0};
   endfunction

   task automatic model_reset();
      m_id = -1; m_ptr = 0; m_hold = 0;
   endtask

   // Apply one clock edge of arbitration rules to the model.
   task automatic model_step();
      logic [4:0] e;
      logic [4:0] others;
      int w;
      if (CD) begin
         model_reset();
         return;
      end
      e = REQ & ~MASK;
      if (m_id < 0) begin
         w = m_search(e, m_ptr);
         if (w >= 0) begin m_id = w; m_hold = 0; m_ptr = (w + 1) % 5; end
      end else begin
         others = e;
         others[m_id] = 1'b0;
         if (!e[m_id] || (m_hold == MAX_HOLD - 1 && others != 5'd0)) begin
            w = m_search(others, m_ptr);
            if (w >= 0) begin m_id = w; m_hold = 0; m_ptr = (w + 1) % 5; end
            else m_id = -1;
         end else if (m_hold == MAX_HOLD - 1) begin
            m_hold = 0;
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic tick();
      @(posedge CK);
      model_step();
      #1;
   endtask

   task automatic sync_reset();
      CD = 1'b1; REQ = 5'd0; MASK = 5'd0;
      tick();
      CD = 1'b0;
   endtask

   task automatic test_reset();
      sync_reset();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'd0) $display("FAIL reset_state: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'd0);
      else n_pass++;
      REQ = 5'b00100;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'b00100_1_010) $display("FAIL reset_first_grant: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'b00100_1_010);
      else n_pass++;
      tick();
      #1 CD = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'd0) $display("FAIL reset_async_clear: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'd0);
      else n_pass++;
      CD = 1'b0;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'b00100_1_010) $display("FAIL reset_regrant: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'b00100_1_010);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      int seq [6] = '{0, 1, 2, 3, 4, 0};
      logic [4:0] eg;
      sync_reset();
      REQ = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         tick();
         eg = 5'b00001 << seq[k];
         n_checks++;
         if ({GNT, GNT_VLD, GNT_ID} !== {eg, 1'b1, 3'(seq[k])})
            $display("FAIL sim_order[%0d]: got %b expected %b", k, {GNT, GNT_VLD, GNT_ID}, {eg, 1'b1, 3'(seq[k])});
         else n_pass++;
         if (k < 4) REQ[seq[k]] = 1'b0;
         else if (k == 4) REQ = 5'b00001;
         else REQ = 5'd0;
      end
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'd0) $display("FAIL sim_idle: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'd0);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int cnt;
      sync_reset();
      REQ = 5'b00010;
      tick();
      REQ = 5'b01010;
      cnt = 1;
      for (int b = 0; b < 20; b++) begin
         tick();
         if (GNT !== 5'b00010) break;
         cnt++;
      end
      n_checks++;
      if (cnt !== 4 || GNT !== 5'b01000) $display("FAIL timeout_handoff: got cycles=%0d GNT=%b expected cycles=4 GNT=01000", cnt, GNT);
      else n_pass++;
      REQ = 5'b00010;
      tick();
      for (int b = 0; b < 12; b++) begin
         n_checks++;
         if ({GNT, GNT_VLD, GNT_ID} !== 9'b00010_1_001 || m_out() !== 9'b00010_1_001)
            $display("FAIL timeout_hold[%0d]: got %b expected %b", b, {GNT, GNT_VLD, GNT_ID}, 9'b00010_1_001);
         else n_pass++;
         tick();
      end
      REQ = 5'd0;
      tick();
   endtask

   task automatic test_masking();
      sync_reset();
      REQ = 5'b00100;
      tick();
      REQ = 5'b00101;
      tick();
      MASK = 5'b00100;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'b00001_1_000) $display("FAIL mask_handoff: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'b00001_1_000);
      else n_pass++;
      MASK = 5'b11111;
      #1;
      n_checks++;
      if (ANY !== 1'b0) $display("FAIL mask_any: got %b expected 0", ANY);
      else n_pass++;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'd0) $display("FAIL mask_all_idle: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'd0);
      else n_pass++;
      MASK = 5'd0; REQ = 5'd0;
      tick();
   endtask

   task automatic test_pointer_wrap();
      sync_reset();
      REQ = 5'b10000;
      tick();
      REQ = 5'd0;
      tick();
      REQ = 5'b10001;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'b00001_1_000) $display("FAIL wrap_to_0: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'b00001_1_000);
      else n_pass++;
      REQ = 5'd0;
      tick();
      REQ = 5'b10001;
      tick();
      n_checks++;
      if ({GNT, GNT_VLD, GNT_ID} !== 9'b10000_1_100) $display("FAIL wrap_next_4: got %b expected %b", {GNT, GNT_VLD, GNT_ID}, 9'b10000_1_100);
      else n_pass++;
      REQ = 5'd0;
      tick();
   endtask

   task automatic test_single();
      REQ = 5'd0;
      tick();
      for (int p = 0; p < 3; p++) begin
         REQ = 5'b01000;
         tick();
         n_checks++;
         if ({GNT, GNT_VLD, GNT_ID} !== 9'b01000_1_011) $display("FAIL single_grant[%0d]: got %b expected %b", p, {GNT, GNT_VLD, GNT_ID}, 9'b01000_1_011);
         else n_pass++;
         REQ = 5'd0;
         tick();
         n_checks++;
         if ({GNT, GNT_VLD, GNT_ID} !== 9'd0) $display("FAIL single_idle[%0d]: got %b expected %b", p, {GNT, GNT_VLD, GNT_ID}, 9'd0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) REQ = 5'($urandom);
         MASK = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
         CD   = ($urandom_range(0, 63) == 0);
         #1;
         n_checks++;
         if (ANY !== |(REQ & ~MASK)) $display("FAIL rand_any[%0d]: got %b expected %b", c, ANY, |(REQ & ~MASK));
         else n_pass++;
         tick();
         n_checks++;
         if ({GNT, GNT_VLD, GNT_ID} !== m_out()) $display("FAIL rand_grant[%0d]: got %b expected %b", c, {GNT, GNT_VLD, GNT_ID}, m_out());
         else n_pass++;
      end
      CD = 1'b0;
   endtask

   initial begin
      CD = 1'b1; REQ = 5'd0; MASK = 5'd0;
      model_reset();
      test_reset();
      test_simultaneous();
      test_timeout();
      test_masking();
      test_pointer_wrap();
      test_single();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
